// File: rtl/riscv_mem_port_arbiter_if.sv
// Bundles the core-side instruction/data memory ports and the shared memory port
// so that the arbiter and its environment connect through one handle.
interface riscv_mem_port_arbiter_if #(
  parameter int REQ_SZ  = 67,
  parameter int RESP_SZ = 35
);
  logic [REQ_SZ-1:0]  imemreq_msg;
  logic               imemreq_val;
  logic               imemreq_rdy;
  logic [RESP_SZ-1:0] imemresp_msg;
  logic               imemresp_val;

  logic [REQ_SZ-1:0]  dmemreq_msg;
  logic               dmemreq_val;
  logic               dmemreq_rdy;
  logic [RESP_SZ-1:0] dmemresp_msg;
  logic               dmemresp_val;

  logic [REQ_SZ-1:0]  memreq_msg;
  logic               memreq_val;
  logic               memreq_rdy;
  logic [RESP_SZ-1:0] memresp_msg;
  logic               memresp_val;

  // Arbiter view.
  modport slave (
    input  imemreq_msg, imemreq_val,
    output imemreq_rdy, imemresp_msg, imemresp_val,
    input  dmemreq_msg, dmemreq_val,
    output dmemreq_rdy, dmemresp_msg, dmemresp_val,
    output memreq_msg, memreq_val,
    input  memreq_rdy, memresp_msg, memresp_val
  );

  // Core plus memory view.
  modport master (
    output imemreq_msg, imemreq_val,
    input  imemreq_rdy, imemresp_msg, imemresp_val,
    output dmemreq_msg, dmemreq_val,
    input  dmemreq_rdy, dmemresp_msg, dmemresp_val,
    input  memreq_msg, memreq_val,
    output memreq_rdy, memresp_msg, memresp_val
  );
endinterface

// File: rtl/riscv_mem_port_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the instruction and
// data ports; an order FIFO of source tags steers each response back to its issuer.
module riscv_mem_port_arbiter #(
  parameter int REQ_SZ    = 67,
  parameter int RESP_SZ   = 35,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  riscv_mem_port_arbiter_if.slave        bus,
  output logic [$clog2(MAX_OUTST):0]     outst_cnt,
  output logic                           err_orphan
);
  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             prio_reg;      // 1 = DMEM wins a tie
  logic             err_orphan_reg;
  logic             tag_mem [MAX_OUTST];

  logic               full;
  logic               empty;
  logic               grant_d;
  logic               can_issue;
  logic               fire;
  logic               pop;
  logic               head_tag;
  logic [REQ_SZ-1:0]  win_msg;
  logic [RESP_SZ-1:0] resp_msg;

  assign full     = (cnt_reg == CNT_W'(MAX_OUTST));
  assign empty    = (cnt_reg == '0);
  assign head_tag = tag_mem[rd_ptr_reg];

  // Data port wins when it is the only requester, or on a tie with priority.
  assign grant_d   = bus.dmemreq_val & (~bus.imemreq_val | prio_reg);
  assign can_issue = reset & bus.memreq_rdy & ~full;
  assign fire      = bus.memreq_val & bus.memreq_rdy;
  assign pop       = reset & bus.memresp_val & ~empty;

  assign win_msg  = grant_d ? bus.dmemreq_msg : bus.imemreq_msg;
  assign resp_msg = bus.memresp_msg;

  assign bus.memreq_msg  = win_msg;
  assign bus.memreq_val  = reset & (bus.imemreq_val | bus.dmemreq_val) & ~full;
  assign bus.dmemreq_rdy = can_issue & grant_d;
  assign bus.imemreq_rdy = can_issue & bus.imemreq_val & ~grant_d;

  assign bus.imemresp_msg = resp_msg;
  assign bus.dmemresp_msg = resp_msg;
  assign bus.imemresp_val = pop & ~head_tag;
  assign bus.dmemresp_val = pop & head_tag;

  assign outst_cnt  = cnt_reg;
  assign err_orphan = err_orphan_reg;

  generate
    for (genvar gi = 0; gi < MAX_OUTST; gi++) begin : g_tag
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          tag_mem[gi] <= 1'b0;
        end else if (fire && wr_ptr_reg == PTR_W'(gi)) begin
          tag_mem[gi] <= grant_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      cnt_reg        <= '0;
      prio_reg       <= 1'b1;
      err_orphan_reg <= 1'b0;
    end else begin
      if (fire) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        prio_reg   <= ~grant_d;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (fire && !pop) begin
        cnt_reg <= cnt_reg + 1'b1;
      end else if (pop && !fire) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
      if (bus.memresp_val && empty) begin
        err_orphan_reg <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Directed bench for riscv_mem_port_arbiter: inputs change after the falling edge,
// outputs are checked 1 ns later, state is checked 1 ns after the rising edge.
module tb_riscv_mem_port_arbiter;
  localparam int REQ_SZ    = 67;
  localparam int RESP_SZ   = 35;
  localparam int MAX_OUTST = 4;

  logic       clk;
  logic       reset;
  logic [2:0] outst_cnt;
  logic       err_orphan;

  int n_tests = 0;
  int n_fail  = 0;

  riscv_mem_port_arbiter_if #(.REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ)) bus ();

  riscv_mem_port_arbiter #(
    .REQ_SZ(REQ_SZ), .RESP_SZ(RESP_SZ), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .outst_cnt(outst_cnt),
    .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [REQ_SZ-1:0]  IMSG = 67'h1_2345_6789_ABCD_EF01;
  localparam logic [REQ_SZ-1:0]  DMSG = 67'h6_FEDC_BA98_7654_3210;

  task automatic idle();
    bus.imemreq_val = 1'b0;
    bus.dmemreq_val = 1'b0;
    bus.memreq_rdy  = 1'b0;
    bus.memresp_val = 1'b0;
  endtask

  task automatic chk_cnt(input string name, input int exp);
    n_tests++;
    if (outst_cnt !== 3'(exp)) begin
      n_fail++;
      $display("FAIL %s: outst_cnt got %0d want %0d", name, outst_cnt, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.imemreq_msg = IMSG;
    bus.dmemreq_msg = DMSG;
    bus.memresp_msg = '0;
    bus.imemreq_val = 1'b1;
    bus.dmemreq_val = 1'b1;
    bus.memreq_rdy  = 1'b1;
    bus.memresp_val = 1'b1;
    #1;
    n_tests++;
    if ({bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_vals: got %b want 00000",
               {bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy, bus.imemresp_val, bus.dmemresp_val});
    end
    chk_cnt("reset_cnt", 0);
    n_tests++;
    if (err_orphan !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", err_orphan);
    end
    @(negedge clk);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk_cnt("reset_release_cnt", 0);
    $display("[TB] reset done");
  endtask

  task automatic test_imem_only();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.imemreq_val = 1'b1;
      bus.imemreq_msg = IMSG + REQ_SZ'(k);
      bus.memreq_rdy  = 1'b1;
      #1;
      n_tests++;
      if (bus.imemreq_rdy !== 1'b1 || bus.dmemreq_rdy !== 1'b0 || bus.memreq_val !== 1'b1 ||
          bus.memreq_msg !== IMSG + REQ_SZ'(k)) begin
        n_fail++;
        $display("FAIL imem_issue%0d: irdy=%b drdy=%b val=%b msg=%h want 1 0 1 %h", k,
                 bus.imemreq_rdy, bus.dmemreq_rdy, bus.memreq_val, bus.memreq_msg, IMSG + REQ_SZ'(k));
      end
      @(posedge clk); #1;
      chk_cnt("imem_cnt_up", k);
      $display("[TB] imem req %0d issued", k);
    end
    @(negedge clk);
    idle();
    for (int k = 1; k <= 3; k++) begin
      bus.memresp_val = 1'b1;
      bus.memresp_msg = 35'h4_0000_0000 | 35'(k);
      #1;
      n_tests++;
      if (bus.imemresp_val !== 1'b1 || bus.dmemresp_val !== 1'b0 ||
          bus.imemresp_msg !== (35'h4_0000_0000 | 35'(k))) begin
        n_fail++;
        $display("FAIL imem_resp%0d: ival=%b dval=%b msg=%h", k,
                 bus.imemresp_val, bus.dmemresp_val, bus.imemresp_msg);
      end
      @(negedge clk);
    end
    idle();
    #1;
    chk_cnt("imem_cnt_drain", 0);
  endtask

  task automatic test_round_robin();
    logic g [4];
    g[0] = 1'b1; g[1] = 1'b0; g[2] = 1'b1; g[3] = 1'b0;
    bus.imemreq_msg = IMSG;
    bus.dmemreq_msg = DMSG;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.imemreq_val = (c < 4);
      bus.dmemreq_val = (c < 4);
      bus.memreq_rdy  = 1'b1;
      bus.memresp_val = (c > 0);
      #1;
      if (c < 4) begin
        n_tests++;
        if (bus.dmemreq_rdy !== g[c] || bus.imemreq_rdy !== !g[c] ||
            bus.memreq_msg !== (g[c] ? DMSG : IMSG)) begin
          n_fail++;
          $display("FAIL rr_grant%0d: drdy=%b irdy=%b msg=%h want dmem=%b", c,
                   bus.dmemreq_rdy, bus.imemreq_rdy, bus.memreq_msg, g[c]);
        end
      end
      if (c > 0) begin
        n_tests++;
        if (bus.dmemresp_val !== g[c-1] || bus.imemresp_val !== !g[c-1]) begin
          n_fail++;
          $display("FAIL rr_resp%0d: dval=%b ival=%b want dmem=%b", c,
                   bus.dmemresp_val, bus.imemresp_val, g[c-1]);
        end
      end
      @(posedge clk); #1;
      chk_cnt("rr_cnt", (c < 4) ? 1 : 0);
      $display("[TB] rr cycle %0d", c);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_full();
    bus.dmemreq_msg = DMSG;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.dmemreq_val = 1'b1;
      bus.memreq_rdy  = 1'b1;
      #1;
      n_tests++;
      if (bus.dmemreq_rdy !== 1'b1 || bus.memreq_val !== 1'b1) begin
        n_fail++;
        $display("FAIL full_fill%0d: drdy=%b val=%b want 1 1", c, bus.dmemreq_rdy, bus.memreq_val);
      end
      @(posedge clk); #1;
      chk_cnt("full_cnt_up", c + 1);
    end
    @(negedge clk);
    bus.memresp_val = 1'b1;
    #1;
    n_tests++;
    if (bus.dmemreq_rdy !== 1'b0 || bus.memreq_val !== 1'b0 || bus.dmemresp_val !== 1'b1) begin
      n_fail++;
      $display("FAIL full_block: drdy=%b val=%b dresp=%b want 0 0 1",
               bus.dmemreq_rdy, bus.memreq_val, bus.dmemresp_val);
    end
    chk_cnt("full_cnt_max", 4);
    @(posedge clk); #1;
    chk_cnt("full_pop", 3);
    @(negedge clk);
    bus.memresp_val = 1'b0;
    #1;
    n_tests++;
    if (bus.dmemreq_rdy !== 1'b1 || bus.memreq_val !== 1'b1) begin
      n_fail++;
      $display("FAIL full_resume: drdy=%b val=%b want 1 1", bus.dmemreq_rdy, bus.memreq_val);
    end
    @(posedge clk); #1;
    chk_cnt("full_refill", 4);
    @(negedge clk);
    idle();
    for (int k = 0; k < 4; k++) begin
      bus.memresp_val = 1'b1;
      #1;
      n_tests++;
      if (bus.dmemresp_val !== 1'b1 || bus.imemresp_val !== 1'b0) begin
        n_fail++;
        $display("FAIL full_drain%0d: dval=%b ival=%b", k, bus.dmemresp_val, bus.imemresp_val);
      end
      @(negedge clk);
    end
    idle();
    #1;
    chk_cnt("full_empty", 0);
    $display("[TB] full scenario done");
  endtask

  task automatic test_stall();
    // One imem transaction first so that DMEM holds priority.
    @(negedge clk);
    bus.imemreq_val = 1'b1;
    bus.memreq_rdy  = 1'b1;
    @(negedge clk);
    idle();
    bus.memresp_val = 1'b1;
    @(negedge clk);
    idle();
    for (int c = 0; c < 2; c++) begin
      bus.imemreq_val = 1'b1;
      bus.dmemreq_val = 1'b1;
      bus.memreq_rdy  = 1'b0;
      #1;
      n_tests++;
      if (bus.memreq_val !== 1'b1 || bus.imemreq_rdy !== 1'b0 || bus.dmemreq_rdy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall%0d: val=%b irdy=%b drdy=%b want 1 0 0", c,
                 bus.memreq_val, bus.imemreq_rdy, bus.dmemreq_rdy);
      end
      @(posedge clk); #1;
      chk_cnt("stall_cnt", 0);
      @(negedge clk);
    end
    bus.memreq_rdy = 1'b1;
    #1;
    n_tests++;
    if (bus.dmemreq_rdy !== 1'b1 || bus.imemreq_rdy !== 1'b0 || bus.memreq_msg !== DMSG) begin
      n_fail++;
      $display("FAIL stall_release: drdy=%b irdy=%b msg=%h", bus.dmemreq_rdy, bus.imemreq_rdy, bus.memreq_msg);
    end
    @(posedge clk); #1;
    chk_cnt("stall_fire", 1);
    @(negedge clk);
    idle();
    bus.memresp_val = 1'b1;
    #1;
    n_tests++;
    if (bus.dmemresp_val !== 1'b1 || bus.imemresp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_resp: dval=%b ival=%b", bus.dmemresp_val, bus.imemresp_val);
    end
    @(negedge clk);
    idle();
    $display("[TB] stall scenario done");
  endtask

  task automatic test_orphan();
    bus.memresp_val = 1'b1;
    #1;
    n_tests++;
    if (bus.imemresp_val !== 1'b0 || bus.dmemresp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL orphan_route: ival=%b dval=%b want 0 0", bus.imemresp_val, bus.dmemresp_val);
    end
    @(posedge clk); #1;
    chk_cnt("orphan_cnt", 0);
    @(negedge clk);
    idle();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (err_orphan !== 1'b1) begin
        n_fail++;
        $display("FAIL orphan_sticky%0d: err=%b want 1", c, err_orphan);
      end
    end
    $display("[TB] orphan scenario done");
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.imemreq_val = 1'b1;
    bus.memreq_rdy  = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk_cnt("areset_pre", 2);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_cnt("areset_cnt", 0);
    n_tests++;
    if (err_orphan !== 1'b0 || bus.memreq_val !== 1'b0 || bus.imemreq_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_outs: err=%b val=%b irdy=%b want 0 0 0", err_orphan, bus.memreq_val, bus.imemreq_rdy);
    end
    @(negedge clk);
    reset = 1'b1;
    bus.imemreq_val = 1'b1;
    bus.dmemreq_val = 1'b1;
    bus.memreq_rdy  = 1'b1;
    #1;
    n_tests++;
    if (bus.dmemreq_rdy !== 1'b1 || bus.imemreq_rdy !== 1'b0 || bus.memreq_msg !== DMSG) begin
      n_fail++;
      $display("FAIL areset_grant: drdy=%b irdy=%b msg=%h", bus.dmemreq_rdy, bus.imemreq_rdy, bus.memreq_msg);
    end
    @(posedge clk); #1;
    chk_cnt("areset_push", 1);
    @(negedge clk);
    idle();
    bus.memresp_val = 1'b1;
    #1;
    n_tests++;
    if (bus.dmemresp_val !== 1'b1 || bus.imemresp_val !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_resp: dval=%b ival=%b", bus.dmemresp_val, bus.imemresp_val);
    end
    @(posedge clk); #1;
    chk_cnt("areset_drain", 0);
    @(negedge clk);
    idle();
    $display("[TB] async reset scenario done");
  endtask

  initial begin
    test_reset();
    test_imem_only();
    test_round_robin();
    test_full();
    test_stall();
    test_orphan();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
